// File: rtl/a_skew_feeder.sv
// Buffers one K-column block of the A operand and streams it into the systolic
// array's left edge with a one-cycle-per-row diagonal skew and zero padding.
module a_skew_feeder #(
  parameter int N      = 4,
  parameter int K      = 4,
  parameter int DATA_W = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                EN,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_col,
  output logic [N*DATA_W-1:0] a_out,
  output logic [N-1:0]        a_valid,
  output logic                busy,
  output logic                done
);

  localparam int LC_W = (K > 1) ? $clog2(K) : 1;
  localparam int T_W  = $clog2(K + N);
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(K - 1);
  localparam logic [T_W-1:0]  T_LAST  = T_W'(K + N - 2);

  typedef enum logic {LOAD, STREAM} state_t;

  state_t              state, state_nxt;
  logic [LC_W-1:0]     lc;
  logic [T_W-1:0]      t;
  logic [DATA_W-1:0]   mem [K][N];
  logic                xfer;
  logic [N*DATA_W-1:0] step_data;
  logic [N-1:0]        step_vld;

  // in_ready also drops while reset is held, so nothing is offered a handshake then
  assign in_ready = RESET && EN && (state == LOAD);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (xfer && (lc == LC_LAST)) state_nxt = STREAM;
      STREAM:  if (EN && (t == T_LAST))     state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      lc <= '0;
      t  <= '0;
    end else if (EN) begin
      if (state == LOAD) begin
        t <= '0;
        if (xfer) lc <= (lc == LC_LAST) ? '0 : lc + 1'b1;
      end else begin
        t <= t + 1'b1;
      end
    end
  end

  // Block buffer: data only, never reset
  always_ff @(posedge CLK) begin
    if (xfer) begin
      for (int k = 0; k < K; k++) begin
        if (lc == LC_W'(k)) begin
          for (int r = 0; r < N; r++) mem[k][r] <= in_col[r*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Lane r carries column t-r when that column exists, otherwise a zero pad
  always_comb begin
    step_data = '0;
    step_vld  = '0;
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < K; k++) begin
        if (t == T_W'(r + k)) begin
          step_data[r*DATA_W +: DATA_W] = mem[k][r];
          step_vld[r]                   = 1'b1;
        end
      end
    end
  end

  // Output register stage
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      a_out   <= '0;
      a_valid <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else if (EN) begin
      busy <= (state_nxt == STREAM);
      if (state == STREAM) begin
        a_out   <= step_data;
        a_valid <= step_vld;
        done    <= (t == T_LAST);
      end else begin
        a_out   <= '0;
        a_valid <= '0;
        done    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_a_skew_feeder.sv
// Scoreboard bench for a_skew_feeder: N=4/K=4 instance for the main scenarios,
// plus an N=4/K=1 instance for the single-column block.
module tb_a_skew_feeder;

  localparam int N  = 4;
  localparam int K  = 4;
  localparam int DW = 32;
  localparam int W  = N * DW;

  typedef struct {
    logic [W-1:0] data;
    logic [N-1:0] vld;
    logic         done;
  } beat_t;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         EN = 1'b0, in_valid = 1'b0, in_ready;
  logic [W-1:0] in_col = '0, a_out;
  logic [N-1:0] a_valid;
  logic         busy, done;

  logic         EN1 = 1'b0, in_valid1 = 1'b0, in_ready1;
  logic [W-1:0] in_col1 = '0, a_out1;
  logic [N-1:0] a_valid1;
  logic         busy1, done1;

  int errors = 0;
  int checks = 0;

  beat_t        q[$];
  beat_t        q1[$];
  logic [DW-1:0] m_buf [K][N];
  bit           m_stream = 0;
  int           m_lc = 0;
  int           m_steps = 0;

  logic [W-1:0] prev_out = '0;
  logic [N-1:0] prev_vld = '0;
  logic         prev_done = 1'b0, prev_busy = 1'b0;

  a_skew_feeder #(.N(N), .K(K), .DATA_W(DW)) u_dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .in_valid(in_valid), .in_ready(in_ready),
    .in_col(in_col), .a_out(a_out), .a_valid(a_valid), .busy(busy), .done(done)
  );

  a_skew_feeder #(.N(N), .K(1), .DATA_W(DW)) u_dut_k1 (
    .CLK(CLK), .RESET(RESET), .EN(EN1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_col(in_col1), .a_out(a_out1), .a_valid(a_valid1), .busy(busy1), .done(done1)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] colv(input int base, input int k);
    logic [W-1:0] c;
    c = '0;
    for (int r = 0; r < N; r++) c[r*DW +: DW] = DW'(base + 16*r + k);
    return c;
  endfunction

  // Expected skewed beats for the block now held in the model buffer
  task automatic push_block();
    beat_t b;
    for (int s = 0; s < K + N - 1; s++) begin
      b.data = '0;
      b.vld  = '0;
      for (int r = 0; r < N; r++) begin
        if (s >= r && s - r < K) begin
          b.data[r*DW +: DW] = m_buf[s-r][r];
          b.vld[r]           = 1'b1;
        end
      end
      b.done = (s == K + N - 2);
      q.push_back(b);
    end
  endtask

  // One clock of stimulus on the main instance, with checks after the edge
  task automatic cycle(input logic en, input logic v, input logic [W-1:0] col);
    logic  xfer;
    beat_t b;
    EN = en; in_valid = v; in_col = col;
    #1;
    check("in_ready", W'(in_ready), W'(en && !m_stream));
    xfer = en && v && !m_stream;
    @(posedge CLK); #1;
    if (!en) begin
      check("hold_a_out", a_out, prev_out);
      check("hold_a_valid", W'(a_valid), W'(prev_vld));
      check("hold_done", W'(done), W'(prev_done));
    end else if (m_stream) begin
      if (q.size() == 0) begin
        check("queue_empty", W'(0), W'(1));
        m_stream = 0;
      end else begin
        b = q.pop_front();
        check("a_out", a_out, b.data);
        check("a_valid", W'(a_valid), W'(b.vld));
        check("done", W'(done), W'(b.done));
        m_steps++;
        if (b.done) m_stream = 0;
      end
    end else begin
      check("load_a_out", a_out, '0);
      check("load_a_valid", W'(a_valid), '0);
      check("load_done", W'(done), '0);
    end
    if (xfer) begin
      for (int r = 0; r < N; r++) m_buf[m_lc][r] = col[r*DW +: DW];
      m_lc++;
      if (m_lc == K) begin
        push_block();
        m_lc = 0;
        m_stream = 1;
        m_steps = 0;
      end
    end
    check("busy", W'(busy), W'(m_stream));
    prev_out = a_out; prev_vld = a_valid; prev_done = done; prev_busy = busy;
  endtask

  task automatic load_block(input bit toggle, input int stall_after, input int base);
    int guard;
    bit stalled;
    guard = 0;
    stalled = 0;
    while (!m_stream && guard < 40) begin
      guard++;
      if (!stalled && stall_after >= 0 && m_lc == stall_after) begin
        repeat (3) cycle(1'b0, 1'b1, colv(base, m_lc));
        stalled = 1;
      end else if (toggle && (guard % 2 == 0)) begin
        cycle(1'b1, 1'b0, colv(base, m_lc));
      end else begin
        cycle(1'b1, 1'b1, colv(base, m_lc));
      end
    end
    if (!m_stream) check("load_timeout", W'(0), W'(1));
  endtask

  task automatic stream_block(input int stall_step, input bit hold_v);
    int guard;
    bit stalled;
    guard = 0;
    stalled = 0;
    while (m_stream && guard < 40) begin
      guard++;
      if (!stalled && stall_step >= 0 && m_steps == stall_step + 1) begin
        repeat (3) cycle(1'b0, hold_v, {$urandom, $urandom, $urandom, $urandom});
        stalled = 1;
      end else begin
        cycle(1'b1, hold_v, {$urandom, $urandom, $urandom, $urandom});
      end
    end
    if (m_stream) check("stream_timeout", W'(0), W'(1));
  endtask

  initial begin
    int guard;
    beat_t b;

    // Reset state
    #3 RESET = 1'b0;
    #2;
    check("rst_a_out", a_out, '0);
    check("rst_a_valid", W'(a_valid), '0);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    EN = 1'b1;
    #1 check("rst_in_ready", W'(in_ready), '0);
    repeat (2) @(posedge CLK);
    #2 RESET = 1'b1;

    // 1: back-to-back load, continuous EN
    load_block(1'b0, -1, 0);
    stream_block(-1, 1'b0);
    cycle(1'b1, 1'b0, '0);

    // 2: in_valid toggling during load
    load_block(1'b1, -1, 0);
    stream_block(-1, 1'b0);
    cycle(1'b1, 1'b0, '0);

    // 3: EN stalls during load after beat 1 and during stream at step 2
    load_block(1'b0, 1, 0);
    stream_block(2, 1'b0);
    cycle(1'b1, 1'b0, '0);

    // 4: reset pulsed at step 3
    load_block(1'b0, -1, 0);
    guard = 0;
    while (m_steps < 4 && guard < 20) begin
      guard++;
      cycle(1'b1, 1'b0, '0);
    end
    #2 RESET = 1'b0;
    #1;
    check("arst_a_out", a_out, '0);
    check("arst_a_valid", W'(a_valid), '0);
    check("arst_busy", W'(busy), '0);
    check("arst_in_ready", W'(in_ready), '0);
    @(posedge CLK); @(posedge CLK);
    #2 check("arst_hold_in_ready", W'(in_ready), '0);
    RESET = 1'b1;
    q.delete();
    m_stream = 0; m_lc = 0; m_steps = 0;
    prev_out = '0; prev_vld = '0; prev_done = 1'b0; prev_busy = 1'b0;
    load_block(1'b0, -1, 0);
    stream_block(-1, 1'b0);
    cycle(1'b1, 1'b0, '0);

    // 5: in_valid held high with changing data during stream
    load_block(1'b0, -1, 0);
    stream_block(-1, 1'b1);
    load_block(1'b0, -1, 'h100);
    stream_block(-1, 1'b0);
    cycle(1'b1, 1'b0, '0);
    check("queue_drained", W'(q.size()), '0);

    // 6: K=1 instance
    @(posedge CLK); #1;
    EN1 = 1'b1; in_valid1 = 1'b1; in_col1 = colv(0, 0);
    #1 check("k1_in_ready", W'(in_ready1), W'(1));
    for (int s = 0; s < N; s++) begin
      b.data = '0;
      b.data[s*DW +: DW] = DW'(16*s);
      b.vld  = N'(1) << s;
      b.done = (s == N - 1);
      q1.push_back(b);
    end
    @(posedge CLK); #1;
    in_valid1 = 1'b0;
    check("k1_busy", W'(busy1), W'(1));
    for (int s = 0; s < N; s++) begin
      @(posedge CLK); #1;
      b = q1.pop_front();
      check("k1_a_out", a_out1, b.data);
      check("k1_a_valid", W'(a_valid1), W'(b.vld));
      check("k1_done", W'(done1), W'(b.done));
    end
    check("k1_in_ready_after", W'(in_ready1), W'(1));
    @(posedge CLK); #1;
    check("k1_zero_a_valid", W'(a_valid1), '0);
    check("k1_zero_done", W'(done1), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
